// File: rtl/z80_bus_pkg.sv
// Shared constants and types for the Z80 I/O channel controller:
// config register offsets, config window code and wait FSM states.
package z80_bus_pkg;

  localparam logic [2:0] CFG_WINDOW = 3'b110;

  localparam logic [3:0] OFF_MASK  = 4'h8;
  localparam logic [3:0] OFF_PEND  = 4'h9;
  localparam logic [3:0] OFF_VBASE = 4'hA;

  // Vector low bits returned when an acknowledge finds nothing pending.
  localparam logic [7:0] VEC_NONE = 8'h0E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HOLD
  } wait_state_e;

endpackage

// File: rtl/z80_wait_counter.sv
// Wait-state down-counter: loads a count, decrements on request and
// flags the last wait cycle (count == 1).
module z80_wait_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (i_dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_done = (count == W'(1));

endmodule

// File: rtl/z80_io_channel_controller.sv
// Z80 I/O channel controller: per-channel IORQ decode, programmable wait
// states, config registers and an IM2 interrupt controller.
module z80_io_channel_controller
  import z80_bus_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WAIT_W     = 3,
  parameter int WAIT_RESET = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_addr,
  input  logic              i_iorq_n,
  input  logic              i_m1_n,
  input  logic              i_rd_n,
  input  logic              i_wr_n,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_data_en,
  input  logic [NUM_CH-1:0] i_irq,
  output logic [NUM_CH-1:0] o_iorq_n,
  output logic              o_wait_n,
  output logic              o_int_n
);

  logic io_cyc, ack_cyc, cfg_sel, rd_act, wr_act, wr_act_q, wr_pulse;
  logic [3:0] off;
  logic unused_addr;

  assign io_cyc      = ~i_iorq_n & i_m1_n;
  assign ack_cyc     = ~i_iorq_n & ~i_m1_n;
  assign cfg_sel     = (i_addr[7:5] == CFG_WINDOW);
  assign off         = i_addr[3:0];
  assign rd_act      = io_cyc & ~i_rd_n & cfg_sel;
  assign wr_act      = io_cyc & ~i_wr_n & cfg_sel;
  assign wr_pulse    = wr_act & ~wr_act_q;
  assign unused_addr = i_addr[4];

  // Config and interrupt state
  logic [WAIT_W-1:0] wait_cfg [NUM_CH];
  logic [WAIT_W-1:0] wait_d   [NUM_CH];
  logic [NUM_CH-1:0] mask, mask_d, pend, pend_d, pend_clr, irq_q, req;
  logic [7:0]        vbase, vbase_d;
  logic              ack_lat, ack_hit, req_any;
  logic [2:0]        ack_idx, req_idx;

  // Lowest-index pending and enabled channel.
  always_comb begin
    req     = pend & mask;
    req_any = |req;
    req_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) req_idx = 3'(k);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wait_d   = wait_cfg;
    mask_d   = mask;
    vbase_d  = vbase;
    pend_clr = '0;
    if (wr_pulse) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (off == 4'(k)) wait_d[k] = i_data[WAIT_W-1:0];
      end
      if (off == OFF_MASK)  mask_d   = i_data[NUM_CH-1:0];
      if (off == OFF_PEND)  pend_clr = i_data[NUM_CH-1:0];
      if (off == OFF_VBASE) vbase_d  = i_data;
    end
    // Acknowledge completes when IORQ returns high.
    if (ack_lat && i_iorq_n && ack_hit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ack_idx == 3'(k)) pend_clr[k] = 1'b1;
      end
    end
    // A new request edge overrides a clear of the same bit.
    pend_d = (pend & ~pend_clr) | (i_irq & ~irq_q);
  end

  // NOTE: the WAIT table is a handful of flops, not a RAM, so it is
  // reset like any other register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_CH; k++) wait_cfg[k] <= WAIT_W'(WAIT_RESET);
      mask     <= '0;
      pend     <= '0;
      vbase    <= '0;
      irq_q    <= '0;
      wr_act_q <= 1'b0;
      o_int_n  <= 1'b1;
      ack_lat  <= 1'b0;
      ack_hit  <= 1'b0;
      ack_idx  <= '0;
    end else begin
      wait_cfg <= wait_d;
      mask     <= mask_d;
      pend     <= pend_d;
      vbase    <= vbase_d;
      irq_q    <= i_irq;
      wr_act_q <= wr_act;
      o_int_n  <= ~|(pend_d & mask_d);
      if (ack_cyc && !ack_lat) begin
        ack_lat <= 1'b1;
        ack_hit <= req_any;
        ack_idx <= req_idx;
      end else if (ack_lat && i_iorq_n) begin
        ack_lat <= 1'b0;
        ack_hit <= 1'b0;
        ack_idx <= '0;
      end
    end
  end

  // Channel strobes and wait-count selection
  logic              ch_hit;
  logic [WAIT_W-1:0] sel_wait;

  always_comb begin
    ch_hit   = 1'b0;
    sel_wait = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      o_iorq_n[k] = ~(io_cyc && i_addr[7:5] == 3'(k));
      if (i_addr[7:5] == 3'(k)) begin
        ch_hit   = 1'b1;
        sel_wait = wait_cfg[k];
      end
    end
  end

  // Wait FSM
  wait_state_e state, state_d;
  logic        cnt_load, cnt_dec, cnt_done;

  always_comb begin
    state_d  = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io_cyc && ch_hit) begin
          if (sel_wait != '0) begin
            cnt_load = 1'b1;
            state_d  = ST_COUNT;
          end else begin
            state_d  = ST_HOLD;
          end
        end
      end
      ST_COUNT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_iorq_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      o_wait_n <= 1'b1;
    end else begin
      state    <= state_d;
      o_wait_n <= (state_d != ST_COUNT);
    end
  end

  z80_wait_counter #(.W(WAIT_W)) u_wait_counter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (cnt_load),
    .i_load_val (sel_wait),
    .i_dec      (cnt_dec),
    .o_done     (cnt_done)
  );

  // Data bus: config read-back or IM2 vector
  logic [7:0] vec;

  always_comb begin
    if (ack_lat) vec = ack_hit ? (vbase | {4'b0, ack_idx, 1'b0}) : (vbase | VEC_NONE);
    else         vec = req_any ? (vbase | {4'b0, req_idx, 1'b0}) : (vbase | VEC_NONE);
  end

  always_comb begin
    o_data    = '0;
    o_data_en = i_reset_n & (rd_act | ack_cyc);
    if (ack_cyc) begin
      o_data = vec;
    end else if (rd_act) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (off == 4'(k)) o_data = 8'(wait_cfg[k]);
      end
      if (off == OFF_MASK)  o_data = 8'(mask);
      if (off == OFF_PEND)  o_data = 8'(pend);
      if (off == OFF_VBASE) o_data = vbase;
    end
  end

endmodule

// File: doc/z80_io_channel_controller.md
Z80_IO_CHANNEL_CONTROLLER -- requirements
Module: z80_io_channel_controller

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of I/O device channels (legal 1..6).
REQ-002 The block SHALL have parameter WAIT_W, default 3, meaning the width of each per-channel wait-state count.
REQ-003 The block SHALL have parameter WAIT_RESET, default 2, meaning the reset value of every channel wait count.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port i_addr, input, 8 bits: Z80 I/O address A7..A0.
REQ-007 The block SHALL have ports i_iorq_n, i_m1_n, i_rd_n and i_wr_n, each input, 1 bit: Z80 bus strobes, active-low.
REQ-008 The block SHALL have port i_data, input, 8 bits: CPU write data.
REQ-009 The block SHALL have port o_data, output, 8 bits: read data or IM2 vector.
REQ-010 The block SHALL have port o_data_en, output, 1 bit: high while the block drives the data bus.
REQ-011 The block SHALL have port i_irq, input, NUM_CH bits: per-channel interrupt requests, active-high, synchronous to i_clk.
REQ-012 The block SHALL have port o_iorq_n, output, NUM_CH bits: per-channel I/O strobes, active-low.
REQ-013 The block SHALL have port o_wait_n, output, 1 bit: Z80 WAIT, active-low.
REQ-014 The block SHALL have port o_int_n, output, 1 bit: Z80 INT, active-low.

Function
REQ-015 io_cyc SHALL be (~i_iorq_n & i_m1_n) and ack_cyc SHALL be (~i_iorq_n & ~i_m1_n).
REQ-016 o_iorq_n[k] SHALL be low (combinationally) exactly when io_cyc and i_addr[7:5]==k.
REQ-017 The config window SHALL be i_addr[7:5]==3'b110 (0xC0); registers are selected by i_addr[3:0]: 0..NUM_CH-1 WAIT[k] (WAIT_W bits), 0x8 MASK, 0x9 PEND, 0xA VBASE (8 bits); other offsets read 0 and ignore writes.
REQ-018 A config write SHALL take effect once per bus cycle, on the first clock with io_cyc, ~i_wr_n and config selected, using a registered wr-strobe edge detect.
REQ-019 A PEND write SHALL clear every bit written as 1; bits written as 0 are unchanged.
REQ-020 In a config read (io_cyc, ~i_rd_n, config selected), o_data_en SHALL be high combinationally and o_data SHALL be the selected register, zero-extended.
REQ-021 The wait FSM SHALL have states IDLE, COUNT and HOLD.
REQ-022 In IDLE, when io_cyc selects channel k with WAIT[k]!=0, the FSM SHALL load the counter with WAIT[k] and go to COUNT; with WAIT[k]==0 it SHALL go to HOLD directly.
REQ-023 o_wait_n SHALL be registered and low exactly in COUNT, i.e. low for WAIT[k] consecutive cycles starting one cycle after detection.
REQ-024 COUNT SHALL decrement each cycle and go to HOLD on count 1.
REQ-025 HOLD SHALL return to IDLE on the first cycle with i_iorq_n high.
REQ-026 Config-window and ack cycles SHALL never insert wait states.
REQ-027 A WAIT[k] write during COUNT SHALL not affect the cycle in progress.
REQ-028 PEND[k] SHALL set on a rising edge of i_irq[k], registered against the previous sample.
REQ-029 When a PEND[k] set and a clear of the same bit coincide, the set SHALL win.
REQ-030 o_int_n SHALL be registered and equal ~|(PEND & MASK).
REQ-031 On the first ack_cyc clock, the block SHALL latch the lowest-index k with PEND[k]&MASK[k].
REQ-032 For the rest of the ack cycle, o_data SHALL be VBASE | (k<<1) and o_data_en SHALL be high.
REQ-033 PEND[k] SHALL clear on the clock at which i_iorq_n returns high, ending the ack cycle.
REQ-034 If no bit is pending at the ack, o_data SHALL be VBASE | 0x0E, with nothing cleared.

Reset
REQ-035 Reset SHALL set: FSM IDLE, counter 0, o_wait_n 1, o_int_n 1, WAIT[*] WAIT_RESET, MASK 0, PEND 0, VBASE 0x00, irq history 0, ack latch cleared.
REQ-036 Reset asserted mid-wait SHALL drive o_wait_n high on the next clock.
REQ-037 o_data_en SHALL be 0 outside qualified read/ack cycles, including during reset.

Structure
REQ-038 Package z80_bus_pkg SHALL hold the register offset constants, the config window code 3'b110 and the wait FSM state typedef.
REQ-039 One sub-module, z80_wait_counter (load/decrement/done), SHALL be instantiated once, since only one I/O cycle is active at a time.

Verification
REQ-040 Write WAIT[1]=3 via OUT (0xC1); then IN from 0x20 -> o_iorq_n[1] low and o_wait_n low for exactly 3 cycles, starting 1 cycle after iorq falls.
REQ-041 WAIT[0]=0; IN from 0x00 -> o_wait_n never low, FSM returns to IDLE after i_iorq_n rises.
REQ-042 MASK=0x06, VBASE=0x40, pulse i_irq[2] then i_irq[1] -> o_int_n low; ack -> o_data=0x42 with o_data_en high; after ack PEND=0x04 and o_int_n stays low; second ack -> 0x44, then o_int_n high.
REQ-043 i_irq[0] rising on the same clock as a PEND write of 0x01 -> PEND[0] remains 1.
REQ-044 Assert i_reset_n low during COUNT with 2 waits remaining -> o_wait_n high next clock; all registers at reset values.
REQ-045 Read 0xC9 with PEND=0x05 -> o_data=0x05 and o_data_en high; read 0xCF -> 0x00.
